// File: rtl/counter_pkg.sv
// Shared definitions for the down_counter timer block.
//   state_t        : FSM state encoding (IDLE, RUN, HOLD, EXPIRED)
//   DEF_WIDTH      : default width of the count and load values
//   DEF_STEP_W     : default width of the decrement step input
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_STEP_W = 8;

endpackage

// File: rtl/sat_sub.sv
// Combinational saturating subtract.
//   a    : minuend
//   b    : subtrahend
//   diff : max(a - b, 0)
//   hit  : 1 when a <= b, meaning the subtraction reached or would pass zero
module sat_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             hit
);

    always_comb begin
        hit  = (a <= b);
        diff = hit ? '0 : (a - b);
    end

endmodule

// File: rtl/down_counter.sv
// Programmable count-down timer. A start value is loaded, then decremented by a
// programmable step on every enabled cycle. A one-cycle done pulse marks expiry;
// with auto-reload the start value is restored and counting continues.
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   load_valid : start-value offer
//   load_ready : load can be accepted (IDLE or EXPIRED)
//   load_val   : start value, captured on load_valid & load_ready
//   auto_rld   : captured with the load; 1 = reload at each expiry
//   x1         : decrement step, 0 behaves as 1
//   en         : count enable; low while running parks the counter in HOLD
//   abort      : leave RUN/HOLD for IDLE keeping the current result
//   result     : current count value
//   busy       : counter is in RUN or HOLD
//   done       : one-cycle pulse when the count reaches zero
module down_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              auto_rld,
    input  logic [STEP_W-1:0] x1,
    input  logic              en,
    input  logic              abort,
    output logic [WIDTH-1:0]  result,
    output logic              busy,
    output logic              done
);

    state_t           state;
    logic [WIDTH-1:0] reload_val;
    logic             rld;

    logic [WIDTH-1:0] eff_step;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_hit;

    // A zero step would stall the timer forever, so it counts as a step of one.
    always_comb begin
        eff_step = (x1 == '0) ? WIDTH'(1) : WIDTH'(x1);
    end

    sat_sub #(
        .WIDTH (WIDTH)
    ) u_sat_sub (
        .a    (result),
        .b    (eff_step),
        .diff (sub_diff),
        .hit  (sub_hit)
    );

    assign load_ready = (state == ST_IDLE) || (state == ST_EXPIRED);
    assign busy       = (state == ST_RUN)  || (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            result     <= '0;
            reload_val <= '0;
            rld        <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Abort outranks a load even in IDLE/EXPIRED; there it is a no-op.
                if (state == ST_RUN || state == ST_HOLD) begin
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_IDLE, ST_EXPIRED: begin
                        if (load_valid) begin
                            result     <= load_val;
                            reload_val <= load_val;
                            rld        <= auto_rld;
                            if (load_val != '0) begin
                                state <= ST_RUN;
                            end else begin
                                // A zero start value expires immediately.
                                state <= ST_EXPIRED;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (!en) begin
                            state <= ST_HOLD;
                        end else if (sub_hit) begin
                            done <= 1'b1;
                            if (rld) begin
                                result <= reload_val;
                            end else begin
                                result <= '0;
                                state  <= ST_EXPIRED;
                            end
                        end else begin
                            result <= sub_diff;
                        end
                    end
                    ST_HOLD: begin
                        // Resume only; the first decrement happens next cycle.
                        if (en) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
